// File: rtl/mips_fetch_pkg.sv
// Shared constants and bundle types for the MIPS instruction-fetch unit.
// Imported by fetch_out_reg and instr_fetch_unit.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_out_t;

  // Clear the byte-offset bits of a fetch address.
  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(
    input logic [31:0] a
  );
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and decode.
// Loads on i_load, drops valid once the consumer takes the word.
module fetch_out_reg
  import mips_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  fetch_out_t i_payload,
  input  logic       i_ready,
  output logic       o_valid,
  output fetch_out_t o_payload
);

  logic       r_valid;
  fetch_out_t r_payload;

  // Capture a new word on load; otherwise retire it when accepted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch: PC, delay-slot redirects, halt, output reg.
// Optional FETCH_ALIGN_CHECK_EN adds addr_err for misaligned targets.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  logic [31:0] r_pc;
  logic        r_active;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic        w_advance;
  logic        w_redir_bad;
  logic [31:0] w_next_pc;
  logic [31:0] w_target;
  logic        w_out_valid;
  fetch_out_t  w_load_data;
  fetch_out_t  w_out_data;

  // Target as it would be loaded; offset bits dropped.
  assign w_target = word_align(redirect_target);

  // Misaligned-target detection, only meaningful with the check built in.
  always_comb begin
    w_redir_bad = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_redir_bad = redirect_valid &&
                  is_misaligned(redirect_target);
`endif
  end

  // Advance and next-PC selection: live redirect, then pending, then +4.
  always_comb begin
    w_advance = r_active && (!w_out_valid || out_ready);
    w_next_pc = r_pc + 32'd4;
    if (redirect_valid)
      w_next_pc = w_target;
    else if (r_pend_valid)
      w_next_pc = r_pend_target;
  end

  // PC register; a rejected target leaves the PC where it is.
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_VECTOR;
    else if (w_advance && !w_redir_bad)
      r_pc <= w_next_pc;
  end

  // Run flag: drops when fetch reaches the halt address or on a bad target.
  always_ff @(posedge clk) begin
    if (reset)
      r_active <= 1'b1;
    else if (w_redir_bad)
      r_active <= 1'b0;
    else if (w_advance && w_next_pc == HALT_ADDR)
      r_active <= 1'b0;
  end

  // Redirects seen while stalled are parked until the next advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_advance) begin
      r_pend_valid  <= 1'b0;
    end else if (redirect_valid && !w_redir_bad) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= w_target;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_addr_err;

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      r_addr_err <= 1'b0;
    else if (w_redir_bad)
      r_addr_err <= 1'b1;
  end

  assign addr_err = r_addr_err;
`endif

  assign w_load_data.instr = instr_readdata;
  assign w_load_data.pc    = r_pc;

  fetch_out_reg u_out (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_load    (w_advance),
    .i_payload (w_load_data),
    .i_ready   (out_ready),
    .o_valid   (w_out_valid),
    .o_payload (w_out_data)
  );

  assign active        = r_active;
  assign instr_address = r_pc;
  assign out_valid     = w_out_valid;
  assign out_instr     = w_out_data.instr;
  assign out_pc        = w_out_data.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a cycle-level reference model.
// Build with FETCH_ALIGN_CHECK_EN to exercise addr_err.
module tb_instr_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  assign instr_readdata = mem(instr_address);

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
`ifdef FETCH_ALIGN_CHECK_EN
    .addr_err        (addr_err),
`endif
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: fetch state as the behaviour rules describe it.
  bit          m_init = 0;
  logic [31:0] m_pc, m_opc, m_oinstr, m_ptgt;
  logic        m_act, m_ov, m_pend, m_err;

  always @(posedge clk) begin
    logic adv, bad;
    logic [31:0] np;
    if (reset) begin
      m_init = 1; m_pc = 32'hBFC0_0000; m_act = 1;
      m_ov = 0; m_opc = 0; m_oinstr = 0;
      m_pend = 0; m_ptgt = 0; m_err = 0;
    end else if (m_init) begin
      bad = ALIGN_EN && redirect_valid &&
            (redirect_target[1:0] != 2'b00);
      adv = m_act && (!m_ov || out_ready);
      if (adv) begin
        m_oinstr = mem(m_pc);
        m_opc = m_pc;
        m_ov = 1;
        if (!bad) begin
          if (redirect_valid) np = redirect_target & ~32'd3;
          else if (m_pend) np = m_ptgt;
          else np = m_pc + 32'd4;
          m_pc = np;
          if (np == 32'h0) m_act = 0;
        end
        m_pend = 0;
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (redirect_valid && !bad) begin
          m_pend = 1;
          m_ptgt = redirect_target & ~32'd3;
        end
      end
      if (bad) begin
        m_err = 1;
        m_act = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("instr_address", instr_address, m_pc);
      chk("active", {31'b0, active}, {31'b0, m_act});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        chk("out_pc", out_pc, m_opc);
        chk("out_instr", out_instr, m_oinstr);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      chk("addr_err", {31'b0, addr_err}, {31'b0, m_err});
`endif
    end
  end

  task automatic step(input logic r, input logic rdy,
                      input logic rv, input logic [31:0] t);
    reset = r;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_target = t;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; out_ready = 0;
    redirect_valid = 0; redirect_target = 0;
    // 1: reset and straight-line fetch
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst addr", instr_address, 32'hBFC0_0000);
    chk("rst valid", {31'b0, out_valid}, 32'd0);
    chk("rst active", {31'b0, active}, 32'd1);
    chk("rst out_pc", out_pc, 32'd0);
    chk("rst out_instr", out_instr, 32'd0);
    step(0, 1, 0, 0);
    chk("t1 addr1", instr_address, 32'hBFC0_0004);
    chk("t1 pc0", out_pc, 32'hBFC0_0000);
    chk("t1 instr0", out_instr, 32'h1A65_5A5A);
    step(0, 1, 0, 0);
    chk("t1 addr2", instr_address, 32'hBFC0_0008);
    chk("t1 pc1", out_pc, 32'hBFC0_0004);
    // 2: three-cycle stall
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t2 hold pc", out_pc, 32'hBFC0_0004);
      chk("t2 hold addr", instr_address, 32'hBFC0_0008);
      chk("t2 hold v", {31'b0, out_valid}, 32'd1);
    end
    step(0, 1, 0, 0);
    chk("t2 resume", out_pc, 32'hBFC0_0008);
    // 3: branch with delay slot
    step(0, 1, 1, 32'hBFC0_0100);
    chk("t3 slot", out_pc, 32'hBFC0_000C);
    chk("t3 addr", instr_address, 32'hBFC0_0100);
    step(0, 1, 0, 0);
    chk("t3 target", out_pc, 32'hBFC0_0100);
    // 4: redirect during stall
    step(0, 0, 1, 32'hBFC0_0200);
    chk("t4 stall addr", instr_address, 32'hBFC0_0104);
    step(0, 1, 0, 0);
    chk("t4 slot", out_pc, 32'hBFC0_0104);
    chk("t4 pend addr", instr_address, 32'hBFC0_0200);
    step(0, 1, 0, 0);
    chk("t4 target", out_pc, 32'hBFC0_0200);
    // 5: redirect to halt address
    step(0, 1, 1, 32'h0);
    chk("t5 slot", out_pc, 32'hBFC0_0204);
    chk("t5 active", {31'b0, active}, 32'd0);
    chk("t5 slot v", {31'b0, out_valid}, 32'd1);
    step(0, 1, 0, 0);
    chk("t5 drained", {31'b0, out_valid}, 32'd0);
    step(0, 1, 0, 0);
    chk("t5 stays", {31'b0, out_valid}, 32'd0);
    // 6: reset mid-stream with a redirect
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'hBFC0_0300);
    chk("t6 pc", instr_address, 32'hBFC0_0000);
    chk("t6 valid", {31'b0, out_valid}, 32'd0);
    // pending overwrite and live-over-pending priority
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'hBFC0_0400);
    step(0, 0, 1, 32'hBFC0_0500);
    step(0, 1, 0, 0);
    chk("ovr addr", instr_address, 32'hBFC0_0500);
    step(0, 0, 1, 32'hBFC0_0600);
    step(0, 1, 1, 32'hBFC0_0700);
    chk("prio addr", instr_address, 32'hBFC0_0700);
    step(0, 1, 0, 0);
    chk("pend clr", instr_address, 32'hBFC0_0704);
    // misaligned target
    step(0, 1, 1, 32'hBFC0_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6b err", {31'b0, addr_err}, 32'd1);
    chk("t6b active", {31'b0, active}, 32'd0);
    chk("t6b hold", instr_address, 32'hBFC0_0704);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t6b drain", {31'b0, out_valid}, 32'd0);
`else
    chk("mask addr", instr_address, 32'hBFC0_0100);
`endif
    // PC wrap at the top of the address space reaches halt
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap addr", instr_address, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap out", out_pc, 32'hFFFF_FFFC);
    chk("wrap pc", instr_address, 32'h0);
    chk("wrap halt", {31'b0, active}, 32'd0);
    step(0, 1, 0, 0);
    chk("wrap drain", {31'b0, out_valid}, 32'd0);
    // irregular back-pressure, model-checked
    step(1, 1, 0, 0);
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom_range(0, 1)), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
